// File: rtl/shift_seq.sv
// rtl/shift_seq.sv - shift-unit sequencer driving an external 32-bit barrel shifter
// Optional flags: define SHIFT_SEQ_FLAGS_EN to compute out_z/out_n/out_c.
module shift_seq (
   input  logic        sys_clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_op,
   input  logic [31:0] in_src,
   input  logic [31:0] in_cnt,
   output logic [1:0]  bar_mux,
   output logic [4:0]  bar_sft,
   output logic        bar_flin,
   output logic [31:0] bar_a,
   input  logic [31:0] bar_z,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_res,
   output logic        out_z,
   output logic        out_n,
   output logic        out_c
);

   typedef enum logic [1:0] {S_IDLE, S_P1, S_P2, S_DONE} state_t;

   state_t      state, state_nxt;
   logic        live;
   logic        accept;
   logic        dec_left, dec_arith, dec_rot;
   logic [5:0]  dec_n;
   logic [31:0] cnt_mag;
   logic [5:0]  sat_n, q_n;
   logic        r_left, r_arith, r_rot;
   logic [5:0]  r_n;
   logic [31:0] r_src;
   logic [31:0] work;
   logic [4:0]  pass_k;

   // 0x8000_0000 negates to itself, which is still > 32 and saturates correctly
   assign cnt_mag = in_cnt[31] ? (32'd0 - in_cnt) : in_cnt;
   assign sat_n   = (cnt_mag > 32'd32) ? 6'd32 : cnt_mag[5:0];
   assign q_n     = ((in_cnt[5:0] == 6'd0) || (in_cnt[5:0] > 6'd32)) ? 6'd32 : in_cnt[5:0];

   always_comb begin
      dec_left  = 1'b0;
      dec_arith = 1'b0;
      dec_rot   = 1'b0;
      dec_n     = sat_n;
      case (in_op)
         3'd1: begin
            dec_left  = in_cnt[31];
            dec_arith = ~in_cnt[31];
         end
         3'd2: begin
            dec_left = 1'b1;
            dec_n    = q_n;
         end
         3'd3: dec_n = q_n;
         3'd4: begin
            dec_arith = 1'b1;
            dec_n     = q_n;
         end
         3'd5, 3'd6: begin
            dec_rot = 1'b1;
            dec_n   = {1'b0, in_cnt[4:0]};
         end
         default: dec_left = in_cnt[31];
      endcase
   end

   // live holds off in_ready for one cycle after reset so every output reads 0 during reset
   assign in_ready = live && (state == S_IDLE) && (~out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept) state_nxt = (dec_n == 6'd0) ? S_DONE : S_P1;
         S_P1:   state_nxt = r_n[5] ? S_P2 : S_DONE;
         S_P2:   state_nxt = S_DONE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // A 32-bit shift is split into 31 then 1 in the same direction
   always_comb begin
      pass_k   = 5'd0;
      bar_a    = 32'd0;
      bar_mux  = 2'b00;
      bar_sft  = 5'd0;
      bar_flin = 1'b0;
      if (state == S_P1 || state == S_P2) begin
         pass_k  = (state == S_P2) ? 5'd1 : (r_n[5] ? 5'd31 : r_n[4:0]);
         bar_a   = (state == S_P2) ? work : r_src;
         bar_mux = r_left ? 2'b00 : (r_rot ? 2'b10 : (r_arith ? 2'b11 : 2'b01));
         bar_sft = r_left ? pass_k : (5'd0 - pass_k);
      end
   end

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         live      <= 1'b0;
         r_left    <= 1'b0;
         r_arith   <= 1'b0;
         r_rot     <= 1'b0;
         r_n       <= 6'd0;
         r_src     <= 32'd0;
         work      <= 32'd0;
         out_valid <= 1'b0;
         out_res   <= 32'd0;
      end else begin
         state <= state_nxt;
         live  <= 1'b1;
         if (accept) begin
            r_left  <= dec_left;
            r_arith <= dec_arith;
            r_rot   <= dec_rot;
            r_n     <= dec_n;
            r_src   <= in_src;
            work    <= in_src;
         end else if (state == S_P1 || state == S_P2) begin
            work <= bar_z;
         end
         if (state == S_DONE) begin
            out_valid <= 1'b1;
            out_res   <= work;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef SHIFT_SEQ_FLAGS_EN
   logic carry;

   always_comb begin
      carry = 1'b0;
      if (r_n != 6'd0) begin
         if (r_rot)
            carry = r_src[31];
         else if (r_left)
            carry = r_src[5'(6'd32 - r_n)];
         else
            carry = r_src[5'(r_n - 6'd1)];
      end
   end

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         out_z <= 1'b0;
         out_n <= 1'b0;
         out_c <= 1'b0;
      end else if (state == S_DONE) begin
         out_z <= (work == 32'd0);
         out_n <= work[31];
         out_c <= carry;
      end
   end
`else
   assign out_z = 1'b0;
   assign out_n = 1'b0;
   assign out_c = 1'b0;
`endif

endmodule
